// File: rtl/sub_div_pkg.sv
// Shared types and constants for the 4-bit subtract/divide unit.
package sub_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int A_W = 8;
  localparam int B_W = 4;

  localparam logic [A_W-1:0] DIV0_QUOTIENT = 8'hFF;

  // Same encoding sense as the add/mul unit: add=1 there, subtract=1 here.
  localparam logic OP_SUB = 1'b1;
  localparam logic OP_DIV = 1'b0;

endpackage

// File: rtl/sub_div_4_bit_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
import sub_div_pkg::*;

module div_step (
  input  logic [B_W:0]   rem_in,
  input  logic           dvd_bit,
  input  logic [B_W-1:0] divisor,
  output logic [B_W:0]   rem_out,
  output logic           q_bit
);

  logic [B_W:0] shifted;

  // Shift, compare and conditionally restore. rem_in[B_W] is always 0 after a
  // restore; if it were ever set the true shifted value would exceed any
  // divisor, so it forces the subtract.
  always_comb begin
    shifted = {rem_in[B_W-1:0], dvd_bit};
    rem_out = shifted;
    q_bit   = 1'b0;
    if (rem_in[B_W] || (shifted >= {1'b0, divisor})) begin
      rem_out = shifted - {1'b0, divisor};
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/sub_div_4_bit.sv
// Sequential subtract / restoring-divide unit with valid/ready on both sides.
// Subtract and divide-by-zero finish in one cycle; a real divide takes
// DIV_STEPS cycles in DIV before the result is presented.
import sub_div_pkg::*;

module sub_div_4_bit #(
  parameter int DIV_STEPS = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           operation,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [A_W-1:0] result,
  output logic [B_W-1:0] remainder,
  output logic           borrow,
  output logic           div0
);

  localparam logic [3:0] LAST_STEP = 4'(DIV_STEPS - 1);

  state_t         state_reg, state_next;
  logic [A_W-1:0] dvd_reg, dvd_next;
  logic [B_W:0]   rem_reg, rem_next;
  logic [A_W-1:0] result_reg, result_next;
  logic [B_W-1:0] b_reg, b_next;
  logic [3:0]     count_reg, count_next;
  logic           borrow_reg, borrow_next;
  logic           div0_reg, div0_next;

  logic [B_W:0]   step_rem;
  logic           step_q;

  div_step u_step (
    .rem_in  (rem_reg),
    .dvd_bit (dvd_reg[A_W-1]),
    .divisor (b_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // State and datapath registers; reset discards any partial operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      dvd_reg    <= '0;
      rem_reg    <= '0;
      result_reg <= '0;
      b_reg      <= '0;
      count_reg  <= '0;
      borrow_reg <= 1'b0;
      div0_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      dvd_reg    <= dvd_next;
      rem_reg    <= rem_next;
      result_reg <= result_next;
      b_reg      <= b_next;
      count_reg  <= count_next;
      borrow_reg <= borrow_next;
      div0_reg   <= div0_next;
    end
  end

  // Next-state and datapath updates. The quotient is built directly in
  // result_reg, one bit shifted in at the LSB per DIV cycle.
  always_comb begin
    state_next  = state_reg;
    dvd_next    = dvd_reg;
    rem_next    = rem_reg;
    result_next = result_reg;
    b_next      = b_reg;
    count_next  = count_reg;
    borrow_next = borrow_reg;
    div0_next   = div0_reg;

    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          borrow_next = 1'b0;
          div0_next   = 1'b0;
          if (operation == OP_SUB) begin
            result_next = a - {4'b0, b};
            borrow_next = (a < {4'b0, b});
            rem_next    = '0;
            state_next  = DONE;
          end else if (b == '0) begin
            result_next = DIV0_QUOTIENT;
            rem_next    = {1'b0, a[B_W-1:0]};
            div0_next   = 1'b1;
            state_next  = DONE;
          end else begin
            dvd_next    = a;
            rem_next    = '0;
            result_next = '0;
            b_next      = b;
            count_next  = '0;
            state_next  = DIV;
          end
        end
      end
      DIV: begin
        dvd_next    = {dvd_reg[A_W-2:0], 1'b0};
        rem_next    = step_rem;
        result_next = {result_reg[A_W-2:0], step_q};
        count_next  = count_reg + 4'd1;
        if (count_reg == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign remainder = rem_reg[B_W-1:0];
  assign borrow    = borrow_reg;
  assign div0      = div0_reg;

endmodule

// File: tb/tb_sub_div_4_bit.sv
// Scoreboard bench for sub_div_4_bit: the driver pushes model results at
// accept time, a monitor pops and compares whenever a result is taken.
module tb_sub_div_4_bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       operation;
  logic [7:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] remainder;
  logic       borrow;
  logic       div0;

  sub_div_4_bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .remainder (remainder),
    .borrow    (borrow),
    .div0      (div0)
  );

  typedef struct {
    logic [7:0] res;
    logic [3:0] rem;
    logic       brw;
    logic       dz;
    int         acc;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;
  int   stall_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter read by driver and monitor at falling edges.
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: plain arithmetic on the operands.
  function automatic exp_t model(input logic op, input logic [7:0] av, input logic [3:0] bv);
    exp_t e;
    int ai, bi;
    ai = int'(av);
    bi = int'(bv);
    e.acc = 0;
    if (op) begin
      e.res = 8'((ai - bi + 256) % 256);
      e.rem = 4'd0;
      e.brw = (ai < bi);
      e.dz  = 1'b0;
      e.lat = 1;
    end else if (bi == 0) begin
      e.res = 8'hFF;
      e.rem = 4'(ai % 16);
      e.brw = 1'b0;
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      e.res = 8'(ai / bi);
      e.rem = 4'(ai % bi);
      e.brw = 1'b0;
      e.dz  = 1'b0;
      e.lat = 9;
    end
    return e;
  endfunction

  // Issue one operation; optionally keep in_valid high with junk while busy.
  task automatic send(input logic op, input logic [7:0] av, input logic [3:0] bv,
                      input int stall, input bit hammer);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid  = 1'b1;
    operation = op;
    a         = av;
    b         = bv;
    stall_cnt = stall;
    e = model(op, av, bv);
    e.acc = ncyc;
    exp_q.push_back(e);
    @(negedge clk);
    if (hammer) begin
      n = 0;
      while (!in_ready && n < 200) begin
        in_valid  = 1'b1;
        operation = 1'($urandom);
        a         = 8'($urandom);
        b         = 4'($urandom);
        @(negedge clk);
        n++;
      end
    end
    in_valid  = 1'b0;
    operation = 1'($urandom);
    a         = 8'($urandom);
    b         = 4'($urandom);
  endtask

  // Backpressure: hold out_ready low for stall_cnt valid cycles.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (out_valid && stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: latency at first valid, stability under backpressure, value at pop.
  initial begin
    bit         seen;
    bit         unexpected;
    logic [7:0] h_res;
    logic [3:0] h_rem;
    logic       h_brw, h_dz;
    exp_t       e;
    seen = 0;
    unexpected = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        seen = 0;
        continue;
      end
      if (out_valid) begin
        chk("ready_while_valid", 32'(in_ready), 32'd0);
        if (!seen) begin
          seen = 1;
          h_res = result; h_rem = remainder; h_brw = borrow; h_dz = div0;
          unexpected = (exp_q.size() == 0);
          if (unexpected) chk("unexpected_result", 32'(out_valid), 32'd0);
          else chk("latency", 32'(ncyc - exp_q[0].acc), 32'(exp_q[0].lat));
        end else begin
          chk("hold_result", 32'(result), 32'(h_res));
          chk("hold_remainder", 32'(remainder), 32'(h_rem));
          chk("hold_flags", 32'({borrow, div0}), 32'({h_brw, h_dz}));
        end
        if (out_ready) begin
          seen = 0;
          if (!unexpected && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("txn: result=%02h rem=%0h borrow=%0b div0=%0b (model %02h %0h %0b %0b)",
                     result, remainder, borrow, div0, e.res, e.rem, e.brw, e.dz);
            chk("result", 32'(result), 32'(e.res));
            chk("remainder", 32'(remainder), 32'(e.rem));
            chk("borrow", 32'(borrow), 32'(e.brw));
            chk("div0", 32'(div0), 32'(e.dz));
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    operation = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_fields", 32'({remainder, borrow, div0}), 32'd0);
    rst = 1'b0;

    // Directed cases
    send(1'b1, 8'h09, 4'h3, 0, 0);
    send(1'b1, 8'h02, 4'h5, 0, 0);
    send(1'b0, 8'hC8, 4'h7, 0, 0);
    send(1'b0, 8'hFF, 4'h1, 0, 0);
    send(1'b0, 8'h55, 4'h0, 0, 0);
    send(1'b0, 8'h64, 4'h9, 5, 1);
    send(1'b1, 8'h3A, 4'hA, 0, 0);
    send(1'b0, 8'h00, 4'h6, 0, 0);
    send(1'b1, 8'h0C, 4'hC, 0, 0);
    send(1'b0, 8'h0B, 4'hE, 0, 0);

    // Reset during the 4th DIV cycle
    send(1'b0, 8'hC8, 4'h7, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(1'b1, 8'h80, 4'hF, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      logic [3:0] rb;
      rb = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      send(1'($urandom), 8'($urandom), rb, int'($urandom_range(0, 3)), 1'($urandom));
    end

    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
